// File: rtl/div_radix2.sv
// -----------------------------------------------------------------------------
// div_radix2
// Multi-cycle radix-2 restoring divider for DIV (signed) and DIVU (unsigned).
// Operates on operand magnitudes and fixes up the signs at the end. The
// quotient takes the XOR of the operand signs; the remainder takes the
// dividend's sign. A zero divisor bypasses the iteration and returns
// {dividend, all-ones}.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   start       request a divide (sampled only in IDLE)
//   signed_div  1 = DIV (two's complement), 0 = DIVU
//   opdata1     dividend (rs)
//   opdata2     divisor  (rt)
//   annul       cancel the in-flight divide; overrides start in IDLE
//   result      {remainder (HI), quotient (LO)}, held until the next completion
//   ready       one-cycle completion strobe (asserted in DONE)
//   stall_req   pipeline freeze request while a divide is accepted but not done
// -----------------------------------------------------------------------------
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 stall_req
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ZERO,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_dividend;   // magnitude, shifted out MSB first
    logic [WIDTH-1:0]     r_divisor;    // magnitude
    logic [WIDTH:0]       r_partial;    // partial remainder
    logic [WIDTH-1:0]     r_quot;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [2*WIDTH-1:0]   r_result;

    // ------------------------------------------------------------------
    // Operand capture helpers
    // ------------------------------------------------------------------
    logic                 w_accept;
    logic                 w_div_zero;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;

    assign w_accept   = (r_state == S_IDLE) && start && !annul && !rst;
    assign w_div_zero = (opdata2 == '0);
    assign w_a_neg    = signed_div & opdata1[WIDTH-1];
    assign w_b_neg    = signed_div & opdata2[WIDTH-1];
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude 2^(WIDTH-1).
    assign w_a_mag    = w_a_neg ? -opdata1 : opdata1;
    assign w_b_mag    = w_b_neg ? -opdata2 : opdata2;

    // ------------------------------------------------------------------
    // One restoring step
    // The trial difference is formed one bit wider than the partial
    // remainder so its MSB is a clean sign bit for the restore decision.
    // ------------------------------------------------------------------
    logic [WIDTH+1:0]     w_shift;
    logic [WIDTH+1:0]     w_diff;
    logic                 w_q_bit;
    logic [WIDTH:0]       w_partial_next;
    logic [WIDTH-1:0]     w_quot_next;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [WIDTH-1:0]     w_quot_fix;
    logic                 w_last;

    assign w_shift        = {r_partial, r_dividend[WIDTH-1]};
    assign w_diff         = w_shift - {2'b00, r_divisor};
    assign w_q_bit        = ~w_diff[WIDTH+1];
    assign w_partial_next = w_q_bit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
    assign w_quot_next    = {r_quot[WIDTH-2:0], w_q_bit};
    assign w_last         = (r_cnt == CNT_W'(WIDTH - 1));

    // After a restoring step the remainder is below the divisor, so the
    // top bit of the partial remainder is always zero here.
    assign w_rem_fix  = r_neg_r ? -w_partial_next[WIDTH-1:0] : w_partial_next[WIDTH-1:0];
    assign w_quot_fix = r_neg_q ? -w_quot_next : w_quot_next;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------
    // NOTE: every output of this block is given a default first so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    always_comb begin
        w_state_next = r_state;
        stall_req    = 1'b0;
        ready        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    stall_req    = 1'b1;
                    w_state_next = w_div_zero ? S_ZERO : S_RUN;
                end
            end
            S_ZERO: begin
                stall_req    = 1'b1;
                w_state_next = annul ? S_IDLE : S_DONE;
            end
            S_RUN: begin
                stall_req = 1'b1;
                if (annul) begin
                    w_state_next = S_IDLE;
                end else if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // stall_req stays low so the pipeline advances with ready.
                ready        = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // NOTE: only the counter and the architectural result are reset; the
    // working registers are always loaded on acceptance before being read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt      <= '0;
                        r_partial  <= '0;
                        r_quot     <= '0;
                        r_divisor  <= w_b_mag;
                        // A zero divisor returns the raw dividend, so keep it
                        // unmodified in that case.
                        r_dividend <= w_div_zero ? opdata1 : w_a_mag;
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                    end
                end
                S_ZERO: begin
                    if (!annul) begin
                        r_result <= {r_dividend, {WIDTH{1'b1}}};
                    end
                end
                S_RUN: begin
                    if (!annul) begin
                        r_partial  <= w_partial_next;
                        r_quot     <= w_quot_next;
                        r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
                        r_cnt      <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_result <= {w_rem_fix, w_quot_fix};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_div_radix2.sv
// -----------------------------------------------------------------------------
// tb_div_radix2
// Self-checking bench for div_radix2 (WIDTH=32). Expected results come from a
// plain-arithmetic reference (64-bit signed / and %, unsigned / and %).
// -----------------------------------------------------------------------------
module tb_div_radix2;

    localparam int W = 32;

    logic            clk;
    logic            rst;
    logic            start;
    logic            signed_div;
    logic [W-1:0]    opdata1;
    logic [W-1:0]    opdata2;
    logic            annul;
    logic [2*W-1:0]  result;
    logic            ready;
    logic            stall_req;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] last_exp = '0;

    div_radix2 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall_req  (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: {remainder, quotient} from plain arithmetic.
    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic s);
        longint sa, sb, q, r;
        logic [W-1:0] uq, ur;
        if (b == '0) return {a, {W{1'b1}}};
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            return {r[W-1:0], q[W-1:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Issue one divide at cycle t and follow it to ready (bounded).
    // lat = cycles from t to ready (-1 if never), stall_cycles counts
    // cycles with stall_req high from t onward.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s, output int lat,
                           output logic [2*W-1:0] res, output int stall_cycles);
        lat = -1;
        res = '0;
        @(posedge clk); #1;
        start = 1'b1; signed_div = s; opdata1 = a; opdata2 = b;
        @(negedge clk);
        stall_cycles = stall_req ? 1 : 0;
        @(posedge clk); #1;
        start = 1'b0;
        // Later operand changes must not affect the accepted divide.
        opdata1 = $urandom; opdata2 = $urandom; signed_div = ~s;
        for (int n = 1; n <= W + 10; n++) begin
            @(negedge clk);
            if (stall_req) stall_cycles++;
            if (ready) begin
                lat = n;
                res = result;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; annul = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_req); end
        checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b want 0", stall_req); end
    endtask

    task automatic test_divu_basic();
        int lat, st;
        logic [2*W-1:0] res;
        run_div(32'd100, 32'd7, 1'b0, lat, res, st);
        checks++; if (res !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_100_7: got %h want %h", res, {32'd2, 32'd14}); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d want 33", lat); end
        checks++; if (st !== 33) begin errors++; $display("FAIL divu_stall_cycles: got %0d want 33", st); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL done_stall: got %b want 0", stall_req); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_one_cycle: got %b want 0", ready); end
        checks++; if (result !== {32'd2, 32'd14}) begin errors++; $display("FAIL result_hold: got %h want %h", result, {32'd2, 32'd14}); end
        last_exp = {32'd2, 32'd14};
    endtask

    task automatic test_signed();
        int lat, st;
        logic [2*W-1:0] res;
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat, res, st);
        checks++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_m7_2: got %h want %h", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, lat, res, st);
        checks++; if (res !== {32'd1, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_7_m2: got %h want %h", res, {32'd1, 32'hFFFF_FFFD}); end
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, res, st);
        checks++; if (res !== {32'd0, 32'h8000_0000}) begin errors++; $display("FAIL div_min_m1: got %h want %h", res, {32'd0, 32'h8000_0000}); end
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, lat, res, st);
        checks++; if (res !== {32'd0, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divu_max_1: got %h want %h", res, {32'd0, 32'hFFFF_FFFF}); end
        last_exp = {32'd0, 32'hFFFF_FFFF};
    endtask

    task automatic test_zero_div();
        int lat, st;
        logic [2*W-1:0] res;
        run_div(32'd5, 32'd0, 1'b0, lat, res, st);
        checks++; if (res !== {32'd5, 32'hFFFF_FFFF}) begin errors++; $display("FAIL divu_5_0: got %h want %h", res, {32'd5, 32'hFFFF_FFFF}); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL zero_latency: got %0d want 2", lat); end
        checks++; if (st !== 2) begin errors++; $display("FAIL zero_stall_cycles: got %0d want 2", st); end
        last_exp = {32'd5, 32'hFFFF_FFFF};
    endtask

    task automatic test_annul();
        int lat, st, nready;
        logic [2*W-1:0] res;
        // Cycle t: start 1000/3.
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        annul = 1'b1;                      // cycle t+10
        @(negedge clk);
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL annul_run_stall: got %b want 1", stall_req); end
        @(posedge clk); #1;
        annul = 1'b0;                      // cycle t+11: back in IDLE
        @(negedge clk);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL annul_idle_stall: got %b want 0", stall_req); end
        nready = 0;
        for (int n = 0; n < W + 5; n++) begin
            @(negedge clk);
            if (ready) nready++;
        end
        checks++; if (nready !== 0) begin errors++; $display("FAIL annul_no_ready: got %0d strobes want 0", nready); end
        checks++; if (result !== last_exp) begin errors++; $display("FAIL annul_result_kept: got %h want %h", result, last_exp); end
        // annul in IDLE overrides start.
        @(posedge clk); #1;
        start = 1'b1; annul = 1'b1; opdata1 = 32'd8; opdata2 = 32'd2;
        @(negedge clk);
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL annul_idle_override: got %b want 0", stall_req); end
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        nready = 0;
        for (int n = 0; n < W + 5; n++) begin
            @(negedge clk);
            if (ready) nready++;
        end
        checks++; if (nready !== 0) begin errors++; $display("FAIL annul_idle_no_ready: got %0d strobes want 0", nready); end
        run_div(32'd9, 32'd3, 1'b0, lat, res, st);
        checks++; if (res !== {32'd0, 32'd3}) begin errors++; $display("FAIL after_annul_9_3: got %h want %h", res, {32'd0, 32'd3}); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL after_annul_latency: got %0d want 33", lat); end
        last_exp = {32'd0, 32'd3};
    endtask

    task automatic test_rst_mid();
        int nready;
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;                        // cycle t+20
        @(posedge clk); #1;
        rst = 1'b0;
        nready = 0;
        for (int n = 0; n < W + 5; n++) begin
            @(negedge clk);
            if (ready) nready++;
        end
        checks++; if (nready !== 0) begin errors++; $display("FAIL rst_mid_no_ready: got %0d strobes want 0", nready); end
        checks++; if (result !== 64'h0) begin errors++; $display("FAIL rst_mid_result: got %h want 0", result); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b want 0", stall_req); end
        last_exp = '0;
    endtask

    task automatic test_start_held();
        int nready, ready_at;
        nready = 0; ready_at = -1;
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd5;
        for (int n = 0; n <= 33; n++) begin
            @(negedge clk);
            if (ready) begin nready++; ready_at = n; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        for (int n = 0; n < W + 5; n++) begin
            @(negedge clk);
            if (ready) nready++;
        end
        checks++; if (nready !== 1) begin errors++; $display("FAIL held_start_single: got %0d strobes want 1", nready); end
        checks++; if (ready_at !== 33) begin errors++; $display("FAIL held_start_latency: got %0d want 33", ready_at); end
        checks++; if (result !== {32'd0, 32'd10}) begin errors++; $display("FAIL held_start_result: got %h want %h", result, {32'd0, 32'd10}); end
        last_exp = {32'd0, 32'd10};
    endtask

    task automatic test_back_to_back();
        int lat, st;
        logic [2*W-1:0] res;
        // annul raised in the DONE cycle must not suppress completion.
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd77; opdata2 = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        annul = 1'b1;                      // cycle t+33 (DONE)
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL annul_in_done_ready: got %b want 1", ready); end
        checks++; if (result !== {32'd2, 32'd15}) begin errors++; $display("FAIL annul_in_done_result: got %h want %h", result, {32'd2, 32'd15}); end
        annul = 1'b0;
        // Next divide starts the cycle right after DONE.
        run_div(32'd123, 32'd10, 1'b0, lat, res, st);
        checks++; if (res !== {32'd3, 32'd12}) begin errors++; $display("FAIL b2b_123_10: got %h want %h", res, {32'd3, 32'd12}); end
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        last_exp = {32'd3, 32'd12};
    endtask

    task automatic test_random();
        int lat, st, exp_lat;
        logic [2*W-1:0] res, exp;
        logic [W-1:0] a, b;
        logic s;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = '0;
                1, 2: b = W'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                4: b = 32'hFFFF_FFFF;
                default: begin end
            endcase
            exp = ref_div(a, b, s);
            exp_lat = (b == '0) ? 2 : 33;
            run_div(a, b, s, lat, res, st);
            checks++; if (res !== exp) begin errors++; $display("FAIL rand_result[%0d] a=%h b=%h s=%b: got %h want %h", i, a, b, s, res, exp); end
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, exp_lat); end
            last_exp = exp;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        opdata1 = '0; opdata2 = '0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_zero_div();
        test_annul();
        test_rst_mid();
        test_start_held();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
